// File: rtl/display_pkg.sv
// Shared constants and types for the multi-digit 7-segment display controller.
// Segment patterns are active-low, ordered abcdefg from bit 6 down to bit 0.
package display_pkg;

    localparam logic [6:0] SEG_DIGITO [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };
    localparam logic [6:0] SEG_TRACO   = 7'b1111110;
    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        ATUALIZA = 2'd2
    } estado_t;

    // Largest value representable with n decimal digits.
    function automatic logic [63:0] limite_decimal(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/display_multiplo_decodificador_7seg.sv
// One-digit BCD to active-low 7-segment decoder with a blanking input.
// Non-decimal nibbles are shown blank.
module decodificador_7seg
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_apaga,
    output logic [6:0] o_segmentos
);

    always_comb begin
        o_segmentos = SEG_APAGADO;
        if (!i_apaga) begin
            case (i_nibble)
                4'd0:    o_segmentos = SEG_DIGITO[0];
                4'd1:    o_segmentos = SEG_DIGITO[1];
                4'd2:    o_segmentos = SEG_DIGITO[2];
                4'd3:    o_segmentos = SEG_DIGITO[3];
                4'd4:    o_segmentos = SEG_DIGITO[4];
                4'd5:    o_segmentos = SEG_DIGITO[5];
                4'd6:    o_segmentos = SEG_DIGITO[6];
                4'd7:    o_segmentos = SEG_DIGITO[7];
                4'd8:    o_segmentos = SEG_DIGITO[8];
                4'd9:    o_segmentos = SEG_DIGITO[9];
                default: o_segmentos = SEG_APAGADO;
            endcase
        end
    end

endmodule

// File: rtl/display_multiplo.sv
// N-digit signed/unsigned binary to 7-segment controller: iterative double-dabble,
// leading-zero suppression, overflow dashes, and a start/busy/done handshake.
module display_multiplo
    import display_pkg::*;
#(
    parameter int NUM_DIGITOS = 4,
    parameter int LARGURA     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LARGURA-1:0]       valor,
    input  logic                     com_sinal,
    input  logic                     supressa_zeros,
    input  logic                     carregar,
    output logic                     ocupado,
    output logic                     pronto,
    output logic                     estouro,
    output logic                     saida_sinal,
    output logic [7*NUM_DIGITOS-1:0] saida_segmentos,
    output logic [1:0]               estado_dbg
);

    localparam int          BW     = 4 * NUM_DIGITOS;
    localparam int          CW     = $clog2(LARGURA + 1);
    localparam logic [63:0] LIMITE = limite_decimal(NUM_DIGITOS);

    estado_t                  r_estado;
    estado_t                  w_prox;
    logic [LARGURA-1:0]       r_mag;
    logic [BW-1:0]            r_bcd;
    logic [CW-1:0]            r_cont;
    logic                     r_neg;
    logic                     r_ovf;
    logic                     r_supr;
    logic                     r_ocupado;
    logic                     r_pronto;
    logic                     r_estouro;
    logic                     r_sinal;
    logic [7*NUM_DIGITOS-1:0] r_seg;

    logic                     w_aceita;
    logic                     w_neg;
    logic [LARGURA-1:0]       w_mag;
    logic                     w_ovf;
    logic                     w_ultimo;
    logic [BW-1:0]            w_bcd_adj;
    logic [NUM_DIGITOS-1:0]   w_apaga;
    logic [7*NUM_DIGITOS-1:0] w_seg;

    assign w_aceita = (r_estado == OCIOSO) && carregar;
    assign w_neg    = com_sinal & valor[LARGURA-1];
    // Two's-complement negate; the most-negative value maps onto itself, which is its magnitude.
    assign w_mag    = w_neg ? (~valor + LARGURA'(1)) : valor;
    assign w_ovf    = (64'(w_mag) > LIMITE);
    assign w_ultimo = (r_cont == CW'(LARGURA - 1));

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            OCIOSO:   if (carregar) w_prox = CONVERTE;
            CONVERTE: if (w_ultimo) w_prox = ATUALIZA;
            ATUALIZA: w_prox = OCIOSO;
            default:  w_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_estado <= OCIOSO;
        else        r_estado <= w_prox;
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < NUM_DIGITOS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    // A digit blanks when suppression is on and it and everything above it are zero.
    always_comb begin
        logic acima;
        acima   = 1'b1;
        w_apaga = '0;
        for (int k = NUM_DIGITOS - 1; k >= 0; k--) begin
            acima      = acima & (r_bcd[4*k +: 4] == 4'd0);
            w_apaga[k] = r_supr & acima & (k != 0);
        end
    end

    for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_digito
        decodificador_7seg u_dec (
            .i_nibble    (r_bcd[4*g +: 4]),
            .i_apaga     (w_apaga[g]),
            .o_segmentos (w_seg[7*g +: 7])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mag     <= '0;
            r_bcd     <= '0;
            r_cont    <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_supr    <= 1'b0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_estouro <= 1'b0;
            r_sinal   <= 1'b1;
            r_seg     <= {NUM_DIGITOS{SEG_APAGADO}};
        end else begin
            r_pronto <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_aceita) begin
                        r_mag     <= w_mag;
                        r_bcd     <= '0;
                        r_cont    <= '0;
                        r_neg     <= w_neg;
                        r_ovf     <= w_ovf;
                        r_supr    <= supressa_zeros;
                        r_ocupado <= 1'b1;
                    end
                end
                CONVERTE: begin
                    r_bcd  <= {w_bcd_adj[BW-2:0], r_mag[LARGURA-1]};
                    r_mag  <= {r_mag[LARGURA-2:0], 1'b0};
                    r_cont <= r_cont + CW'(1);
                end
                ATUALIZA: begin
                    r_ocupado <= 1'b0;
                    r_pronto  <= 1'b1;
                    r_estouro <= r_ovf;
                    r_sinal   <= r_ovf ? 1'b1 : ~r_neg;
                    r_seg     <= r_ovf ? {NUM_DIGITOS{SEG_TRACO}} : w_seg;
                end
                default: ;
            endcase
        end
    end

    assign ocupado         = r_ocupado;
    assign pronto          = r_pronto;
    assign estouro         = r_estouro;
    assign saida_sinal     = r_sinal;
    assign saida_segmentos = r_seg;
    assign estado_dbg      = r_estado;

endmodule

// File: tb/tb_display_multiplo.sv
// Directed bench for display_multiplo (4 digits, 16-bit input).
module tb_display_multiplo;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                           S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                           S6 = 7'b0100000, S8 = 7'b0000000, S9 = 7'b0000100,
                           SD = 7'b1111110, SB = 7'b1111111;

    logic        clk;
    logic        rst_n;
    logic [15:0] valor;
    logic        com_sinal;
    logic        supressa_zeros;
    logic        carregar;
    logic        ocupado;
    logic        pronto;
    logic        estouro;
    logic        saida_sinal;
    logic [27:0] saida_segmentos;
    logic [1:0]  estado_dbg;

    int n_checks;
    int n_fails;

    display_multiplo #(.NUM_DIGITOS(4), .LARGURA(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valor           (valor),
        .com_sinal       (com_sinal),
        .supressa_zeros  (supressa_zeros),
        .carregar        (carregar),
        .ocupado         (ocupado),
        .pronto          (pronto),
        .estouro         (estouro),
        .saida_sinal     (saida_sinal),
        .saida_segmentos (saida_segmentos),
        .estado_dbg      (estado_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts one conversion and waits for pronto; lat = edges from acceptance, -1 on timeout.
    task automatic converte(input logic [15:0] v, input logic s, input logic z,
                            output int lat, output logic segurou);
        logic [27:0] antes;
        @(negedge clk);
        valor = v; com_sinal = s; supressa_zeros = z; carregar = 1'b1;
        antes   = saida_segmentos;
        segurou = 1'b1;
        @(posedge clk); #1;
        carregar = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (pronto) begin
                lat = i;
                break;
            end
            if (saida_segmentos !== antes) segurou = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; valor = '0; com_sinal = 1'b0; supressa_zeros = 1'b0; carregar = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (saida_segmentos !== {4{SB}}) begin n_fails++; $display("FAIL reset_seg: got %b expected %b", saida_segmentos, {4{SB}}); end
        n_checks++;
        if ({saida_sinal, ocupado, pronto, estouro} !== 4'b1000) begin n_fails++; $display("FAIL reset_flags: got %b expected 1000", {saida_sinal, ocupado, pronto, estouro}); end
        n_checks++;
        if (estado_dbg !== 2'd0) begin n_fails++; $display("FAIL reset_state: got %0d expected 0", estado_dbg); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_basic;
        int lat; logic seg;
        converte(16'd1234, 1'b0, 1'b0, lat, seg);
        n_checks++;
        if (lat !== 17) begin n_fails++; $display("FAIL latency_1234: got %0d expected 17", lat); end
        n_checks++;
        if (seg !== 1'b1) begin n_fails++; $display("FAIL hold_during_conv: got %b expected 1", seg); end
        n_checks++;
        if (saida_segmentos !== {S1, S2, S3, S4}) begin n_fails++; $display("FAIL seg_1234: got %b expected %b", saida_segmentos, {S1, S2, S3, S4}); end
        n_checks++;
        if ({estouro, saida_sinal, ocupado} !== 3'b010) begin n_fails++; $display("FAIL flags_1234: got %b expected 010", {estouro, saida_sinal, ocupado}); end
        @(posedge clk); #1;
        n_checks++;
        if (pronto !== 1'b0) begin n_fails++; $display("FAIL pronto_pulse: got %b expected 0", pronto); end
    endtask

    task automatic test_reset_mid;
        int lat; logic seg; logic pulsou;
        @(negedge clk);
        valor = 16'd5678; com_sinal = 1'b0; supressa_zeros = 1'b0; carregar = 1'b1;
        @(posedge clk); #1;
        carregar = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (saida_segmentos !== {4{SB}}) begin n_fails++; $display("FAIL midreset_seg: got %b expected %b", saida_segmentos, {4{SB}}); end
        n_checks++;
        if ({saida_sinal, ocupado, estouro} !== 3'b100) begin n_fails++; $display("FAIL midreset_flags: got %b expected 100", {saida_sinal, ocupado, estouro}); end
        @(negedge clk);
        rst_n  = 1'b1;
        pulsou = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (pronto) pulsou = 1'b1;
        end
        n_checks++;
        if (pulsou !== 1'b0) begin n_fails++; $display("FAIL midreset_no_pronto: got %b expected 0", pulsou); end
        converte(16'd42, 1'b0, 1'b0, lat, seg);
        n_checks++;
        if (lat !== 17) begin n_fails++; $display("FAIL latency_after_reset: got %0d expected 17", lat); end
        n_checks++;
        if (saida_segmentos !== {S0, S0, S4, S2}) begin n_fails++; $display("FAIL seg_after_reset: got %b expected %b", saida_segmentos, {S0, S0, S4, S2}); end
    endtask

    task automatic test_signed_suppress;
        int lat; logic seg;
        converte(16'hFFFB, 1'b1, 1'b1, lat, seg);
        n_checks++;
        if (saida_segmentos !== {SB, SB, SB, S5}) begin n_fails++; $display("FAIL seg_minus5: got %b expected %b", saida_segmentos, {SB, SB, SB, S5}); end
        n_checks++;
        if ({saida_sinal, estouro} !== 2'b00) begin n_fails++; $display("FAIL sign_minus5: got %b expected 00", {saida_sinal, estouro}); end
        converte(16'd80, 1'b0, 1'b1, lat, seg);
        n_checks++;
        if (saida_segmentos !== {SB, SB, S8, S0}) begin n_fails++; $display("FAIL seg_80_supr: got %b expected %b", saida_segmentos, {SB, SB, S8, S0}); end
        converte(16'd1005, 1'b0, 1'b1, lat, seg);
        n_checks++;
        if (saida_segmentos !== {S1, S0, S0, S5}) begin n_fails++; $display("FAIL seg_1005_supr: got %b expected %b", saida_segmentos, {S1, S0, S0, S5}); end
    endtask

    task automatic test_zero;
        int lat; logic seg;
        converte(16'd0, 1'b1, 1'b1, lat, seg);
        n_checks++;
        if (saida_segmentos !== {SB, SB, SB, S0}) begin n_fails++; $display("FAIL seg_zero_supr: got %b expected %b", saida_segmentos, {SB, SB, SB, S0}); end
        n_checks++;
        if (saida_sinal !== 1'b1) begin n_fails++; $display("FAIL sign_zero: got %b expected 1", saida_sinal); end
        converte(16'd0, 1'b0, 1'b0, lat, seg);
        n_checks++;
        if (saida_segmentos !== {4{S0}}) begin n_fails++; $display("FAIL seg_zero_full: got %b expected %b", saida_segmentos, {4{S0}}); end
    endtask

    task automatic test_overflow;
        int lat; logic seg;
        converte(16'd10000, 1'b0, 1'b0, lat, seg);
        n_checks++;
        if ({estouro, saida_sinal, saida_segmentos} !== {2'b11, {4{SD}}}) begin n_fails++; $display("FAIL ovf_10000: got %b expected %b", {estouro, saida_sinal, saida_segmentos}, {2'b11, {4{SD}}}); end
        converte(16'h8000, 1'b1, 1'b0, lat, seg);
        n_checks++;
        if ({estouro, saida_sinal, saida_segmentos} !== {2'b11, {4{SD}}}) begin n_fails++; $display("FAIL ovf_minmax: got %b expected %b", {estouro, saida_sinal, saida_segmentos}, {2'b11, {4{SD}}}); end
        converte(16'd9999, 1'b0, 1'b0, lat, seg);
        n_checks++;
        if ({estouro, saida_sinal, saida_segmentos} !== {2'b01, {4{S9}}}) begin n_fails++; $display("FAIL ovf_9999: got %b expected %b", {estouro, saida_sinal, saida_segmentos}, {2'b01, {4{S9}}}); end
        converte(16'hD8F1, 1'b1, 1'b0, lat, seg);
        n_checks++;
        if ({estouro, saida_sinal, saida_segmentos} !== {2'b00, {4{S9}}}) begin n_fails++; $display("FAIL ovf_minus9999: got %b expected %b", {estouro, saida_sinal, saida_segmentos}, {2'b00, {4{S9}}}); end
    endtask

    task automatic test_back_to_back;
        logic        exp_pr;
        logic        exp_oc;
        logic [27:0] exp_seg;
        int          lat;
        com_sinal = 1'b0; supressa_zeros = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            valor = 16'(100 + k); carregar = 1'b1;
            @(posedge clk); #1;
            exp_pr = (k == 17) || (k == 35);
            exp_oc = !exp_pr;
            n_checks++;
            if ({pronto, ocupado} !== {exp_pr, exp_oc}) begin n_fails++; $display("FAIL b2b_handshake k=%0d: got %b expected %b", k, {pronto, ocupado}, {exp_pr, exp_oc}); end
            if (exp_pr) begin
                exp_seg = (k == 17) ? {S0, S1, S0, S0} : {S0, S1, S1, S8};
                n_checks++;
                if (saida_segmentos !== exp_seg) begin n_fails++; $display("FAIL b2b_seg k=%0d: got %b expected %b", k, saida_segmentos, exp_seg); end
            end
        end
        @(negedge clk);
        carregar = 1'b0;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (pronto) begin lat = i; break; end
        end
        n_checks++;
        if (lat !== 13) begin n_fails++; $display("FAIL b2b_third_latency: got %0d expected 13", lat); end
        n_checks++;
        if (saida_segmentos !== {S0, S1, S3, S6}) begin n_fails++; $display("FAIL b2b_third_seg: got %b expected %b", saida_segmentos, {S0, S1, S3, S6}); end
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        test_reset();
        test_unsigned_basic();
        test_reset_mid();
        test_signed_suppress();
        test_zero();
        test_overflow();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
